// File: rtl/vector_operand_loader.sv
// Serial-to-parallel operand loader: shifts WIDTH bits of a then WIDTH bits of b
// (MSB first) and presents them as a registered pair through a valid/ready output.
module vector_operand_loader #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             in_bit,
  output logic             in_ready,
  input  logic             abort,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic [7:0]       pair_count,
  output logic [1:0]       dbg_state_o
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    LOAD_A = 2'd0,
    LOAD_B = 2'd1,
    FULL   = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sa_q, sa_d;
  logic [WIDTH-1:0] sb_q, sb_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             out_valid_q, out_valid_d;
  logic [7:0]       pair_count_q, pair_count_d;

  // Handshakes: a bit moves when in_valid && in_ready && !abort at a rising
  // edge; a pair moves when out_valid && out_ready at a rising edge. Neither
  // side may make valid depend on ready.
  logic             accept;
  logic             last_bit;
  logic             slot_free;
  logic             out_hs;
  logic [WIDTH:0]   sa_ext;
  logic [WIDTH:0]   sb_ext;
  logic [WIDTH-1:0] sa_shift;
  logic [WIDTH-1:0] sb_shift;

  assign in_ready  = (state_q != FULL);
  assign accept    = in_valid && in_ready && !abort;
  assign last_bit  = (cnt_q == CW'(WIDTH - 1));
  assign slot_free = !out_valid_q || out_ready;
  assign out_hs    = out_valid_q && out_ready;
  assign sa_ext    = {sa_q, in_bit};
  assign sb_ext    = {sb_q, in_bit};
  assign sa_shift  = sa_ext[WIDTH-1:0];
  assign sb_shift  = sb_ext[WIDTH-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= LOAD_A;
      cnt_q        <= '0;
      sa_q         <= '0;
      sb_q         <= '0;
      a_q          <= '0;
      b_q          <= '0;
      out_valid_q  <= 1'b0;
      pair_count_q <= 8'd0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      sa_q         <= sa_d;
      sb_q         <= sb_d;
      a_q          <= a_d;
      b_q          <= b_d;
      out_valid_q  <= out_valid_d;
      pair_count_q <= pair_count_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    sa_d         = sa_q;
    sb_d         = sb_q;
    a_d          = a_q;
    b_d          = b_q;
    out_valid_d  = out_valid_q;
    pair_count_d = pair_count_q;

    // The consumed pair drops out_valid unless a transfer below refills it.
    if (out_hs) begin
      out_valid_d  = 1'b0;
      pair_count_d = pair_count_q + 8'd1;
    end

    if (abort) begin
      state_d = LOAD_A;
      cnt_d   = '0;
      sa_d    = '0;
      sb_d    = '0;
    end else begin
      case (state_q)
        LOAD_A: begin
          if (accept) begin
            sa_d = sa_shift;
            if (last_bit) begin
              cnt_d   = '0;
              state_d = LOAD_B;
            end else begin
              cnt_d = cnt_q + CW'(1);
            end
          end
        end
        LOAD_B: begin
          if (accept) begin
            sb_d = sb_shift;
            if (last_bit) begin
              cnt_d = '0;
              if (slot_free) begin
                a_d         = sa_q;
                b_d         = sb_shift;
                out_valid_d = 1'b1;
                state_d     = LOAD_A;
              end else begin
                state_d = FULL;
              end
            end else begin
              cnt_d = cnt_q + CW'(1);
            end
          end
        end
        FULL: begin
          if (slot_free) begin
            a_d         = sa_q;
            b_d         = sb_q;
            out_valid_d = 1'b1;
            state_d     = LOAD_A;
          end
        end
        default: begin
          state_d = LOAD_A;
          cnt_d   = '0;
        end
      endcase
    end
  end

  assign a           = a_q;
  assign b           = b_q;
  assign out_valid   = out_valid_q;
  assign pair_count  = pair_count_q;
  assign busy        = (state_q != LOAD_A) || (cnt_q != '0);
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_vector_operand_loader.sv
// Bench for vector_operand_loader: table of operand pairs through a scoreboard,
// plus directed sequences for back-pressure, abort, async reset and count wrap.
module tb_vector_operand_loader;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_bit;
  logic         in_ready;
  logic         abort;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic         busy;
  logic [7:0]   pair_count;
  logic [1:0]   dbg_state;

  vector_operand_loader #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_bit     (in_bit),
    .in_ready   (in_ready),
    .abort      (abort),
    .a          (a),
    .b          (b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .busy       (busy),
    .pair_count (pair_count),
    .dbg_state_o(dbg_state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a_in;
    logic [W-1:0] b_in;
    int           gap;
    logic [W-1:0] exp_a;
    logic [W-1:0] exp_b;
  } vec_t;

  logic [2*W-1:0] exp_q[$];
  int n_pass  = 0;
  int n_total = 0;
  int hs_seen = 0;
  int hs_base = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Every output handshake pops one expected pair and checks the running count.
  task automatic monitor_loop();
    logic [2*W-1:0] e;
    forever begin
      @(negedge clk);
      if (!rst && out_valid && out_ready) begin
        chk("pair_count_at_hs", {24'd0, pair_count}, {24'd0, 8'(hs_seen - hs_base)});
        if (exp_q.size() == 0) begin
          chk("unexpected_pair", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("pair_ab", {24'd0, a, b}, {24'd0, e});
        end
        hs_seen++;
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_a", {28'd0, a}, 32'd0);
    chk("rst_b", {28'd0, b}, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_pair_count", {24'd0, pair_count}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    exp_q.delete();
    hs_base = hs_seen;
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic bv, input int gap);
    int n = 0;
    while (!in_ready && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!in_ready) chk("in_ready_timeout", 32'd0, 32'd1);
    in_valid = 1'b1;
    in_bit   = bv;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_bit   = 1'b0;
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_pair(input logic [W-1:0] av, input logic [W-1:0] bv, input int gap,
                           input logic [W-1:0] ea, input logic [W-1:0] eb);
    exp_q.push_back({ea, eb});
    for (int i = W - 1; i >= 0; i--) send_bit(av[i], gap);
    for (int i = W - 1; i >= 0; i--) send_bit(bv[i], gap);
  endtask

  vec_t vecs[6];

  initial begin
    logic [W-1:0] ra, rb;
    vecs[0] = '{a_in: 4'hA, b_in: 4'h6, gap: 0, exp_a: 4'hA, exp_b: 4'h6};
    vecs[1] = '{a_in: 4'hF, b_in: 4'h1, gap: 1, exp_a: 4'hF, exp_b: 4'h1};
    vecs[2] = '{a_in: 4'h3, b_in: 4'hC, gap: 0, exp_a: 4'h3, exp_b: 4'hC};
    vecs[3] = '{a_in: 4'h0, b_in: 4'h0, gap: 0, exp_a: 4'h0, exp_b: 4'h0};
    vecs[4] = '{a_in: 4'hF, b_in: 4'hF, gap: 2, exp_a: 4'hF, exp_b: 4'hF};
    vecs[5] = '{a_in: 4'h5, b_in: 4'hA, gap: 0, exp_a: 4'h5, exp_b: 4'hA};

    rst = 1'b1; in_valid = 1'b0; in_bit = 1'b0; abort = 1'b0; out_ready = 1'b1;
    fork
      monitor_loop();
    join_none

    // Basic A/6 with one-cycle latency and count after handshake.
    do_reset();
    send_pair(4'hA, 4'h6, 0, 4'hA, 4'h6);
    chk("lat_out_valid", {31'd0, out_valid}, 32'd1);
    chk("lat_a", {28'd0, a}, 32'hA);
    chk("lat_b", {28'd0, b}, 32'h6);
    @(posedge clk); #1;
    chk("hs_pair_count", {24'd0, pair_count}, 32'd1);
    chk("hs_out_valid", {31'd0, out_valid}, 32'd0);
    chk("hs_a_retained", {28'd0, a}, 32'hA);

    // Table of pairs, including gapped input and back-to-back pairs.
    for (int i = 0; i < 6; i++)
      send_pair(vecs[i].a_in, vecs[i].b_in, vecs[i].gap, vecs[i].exp_a, vecs[i].exp_b);
    repeat (2) @(posedge clk); #1;

    // Back-pressure: second pair parks in FULL, then transfers with handshake.
    do_reset();
    out_ready = 1'b0;
    send_pair(4'hA, 4'h6, 0, 4'hA, 4'h6);
    send_pair(4'h3, 4'hC, 0, 4'h3, 4'hC);
    chk("full_in_ready", {31'd0, in_ready}, 32'd0);
    chk("full_state", {30'd0, dbg_state}, 32'd2);
    chk("full_busy", {31'd0, busy}, 32'd1);
    chk("full_a_held", {28'd0, a}, 32'hA);
    chk("full_b_held", {28'd0, b}, 32'h6);
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("drain_a", {28'd0, a}, 32'h3);
    chk("drain_b", {28'd0, b}, 32'hC);
    chk("drain_out_valid", {31'd0, out_valid}, 32'd1);
    chk("drain_pair_count", {24'd0, pair_count}, 32'd1);
    repeat (2) @(posedge clk); #1;

    // Abort mid-load together with a 4th bit.
    send_bit(1'b1, 0); send_bit(1'b1, 0); send_bit(1'b1, 0);
    chk("mid_busy", {31'd0, busy}, 32'd1);
    in_valid = 1'b1; in_bit = 1'b1; abort = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; abort = 1'b0;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    send_pair(4'h5, 4'h9, 0, 4'h5, 4'h9);
    chk("abort_a", {28'd0, a}, 32'h5);
    chk("abort_b", {28'd0, b}, 32'h9);
    repeat (2) @(posedge clk); #1;

    // Abort in FULL wins over the transfer; the held pair still hands off.
    out_ready = 1'b0;
    send_pair(4'h7, 4'h2, 0, 4'h7, 4'h2);
    send_pair(4'hE, 4'hD, 0, 4'hE, 4'hD);
    void'(exp_q.pop_back());
    abort = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    chk("fabort_out_valid", {31'd0, out_valid}, 32'd0);
    chk("fabort_a", {28'd0, a}, 32'h7);
    chk("fabort_busy", {31'd0, busy}, 32'd0);
    chk("fabort_in_ready", {31'd0, in_ready}, 32'd1);
    send_pair(4'h1, 4'h8, 0, 4'h1, 4'h8);
    repeat (2) @(posedge clk); #1;

    // Asynchronous reset while FULL with out_valid high.
    out_ready = 1'b0;
    send_pair(4'hA, 4'h6, 0, 4'hA, 4'h6);
    send_pair(4'h3, 4'hC, 0, 4'h3, 4'hC);
    #2 rst = 1'b1;
    #1;
    chk("arst_a", {28'd0, a}, 32'd0);
    chk("arst_b", {28'd0, b}, 32'd0);
    chk("arst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("arst_pair_count", {24'd0, pair_count}, 32'd0);
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_in_ready", {31'd0, in_ready}, 32'd1);
    out_ready = 1'b1;
    do_reset();

    // 256 handshakes wrap the pair counter.
    for (int i = 0; i < 256; i++) begin
      ra = W'($urandom_range(0, 15));
      rb = W'($urandom_range(0, 15));
      send_pair(ra, rb, 0, ra, rb);
    end
    repeat (2) @(posedge clk); #1;
    chk("wrap_pair_count", {24'd0, pair_count}, 32'd0);
    chk("wrap_hs_total", 32'(hs_seen - hs_base), 32'd256);

    repeat (3) @(posedge clk); #1;
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/vector_operand_loader.md
VECTOR_OPERAND_LOADER -- requirements
Module: vector_operand_loader

Interface
REQ-001 Parameter WIDTH, default 4: operand width in bits; the WIDTH-bit outputs drive the downstream vector operator's a/b inputs.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 in_valid  input  1  serial bit present on in_bit.
REQ-005 in_bit  input  1  serial operand data.
REQ-006 in_ready  output  1  loader can accept a bit this cycle.
REQ-007 abort  input  1  synchronous discard of a partially loaded pair.
REQ-008 a  output  WIDTH  operand a, registered.
REQ-009 b  output  WIDTH  operand b, registered.
REQ-010 out_valid  output  1  a/b hold a complete pair.
REQ-011 out_ready  input  1  downstream consumes the pair.
REQ-012 busy  output  1  partial or complete pair held internally, not yet transferred.
REQ-013 pair_count  output  8  number of output handshakes, mod 256.

Function
REQ-014 Bit accept SHALL occur when in_valid && in_ready && !abort.
REQ-015 Serial order SHALL be: WIDTH bits of a, MSB first, then WIDTH bits of b, MSB first, shifted into internal registers sa/sb (sx <= {sx[WIDTH-2:0], in_bit}).
REQ-016 States SHALL be LOAD_A, LOAD_B, FULL; a bit counter 0..WIDTH-1 SHALL track position within the current operand.
REQ-017 LOAD_A -> LOAD_B on the WIDTH-th accepted bit; the counter clears.
REQ-018 Define slot_free = !out_valid || out_ready.
REQ-019 On the WIDTH-th accepted bit in LOAD_B: if slot_free, a<=sa', b<=sb' (including that bit), out_valid<=1, state -> LOAD_A. Otherwise state -> FULL.
REQ-020 In FULL, in_ready SHALL be 0; when slot_free, a<=sa, b<=sb, out_valid<=1, state -> LOAD_A.
REQ-021 in_ready SHALL be 1 in LOAD_A and LOAD_B, 0 in FULL (combinational from state only).
REQ-022 Latency: out_valid and the new a/b SHALL be visible the cycle after the last b bit is accepted when the slot is free.
REQ-023 On out_valid && out_ready with no transfer in the same cycle, out_valid<=0; a/b SHALL retain their values.
REQ-024 A transfer and an output handshake in the same cycle SHALL keep out_valid=1 and load the new pair; no cycle gap.
REQ-025 a/b SHALL change only on a transfer; they never expose partial shift contents.
REQ-026 pair_count SHALL increment on each out_valid && out_ready, wrapping 255 -> 0.
REQ-027 abort SHALL clear sa, sb, and the bit counter and force LOAD_A, including from FULL (the completed pair is dropped); a, b, out_valid, and pair_count are unaffected.
REQ-028 abort SHALL take priority over a bit accept and over a FULL-state transfer in the same cycle.
REQ-029 busy SHALL be 1 when state != LOAD_A or the bit counter != 0.

Reset
REQ-030 While rst=1: state=LOAD_A, counter=0, sa=sb=0, a=b=0, out_valid=0, pair_count=0, busy=0, in_ready=1.
REQ-031 Reset asserted mid-load or in FULL SHALL discard all partial or complete data immediately, without waiting for a clock edge.

Verification
REQ-032 With out_ready=1, stream bits 1,0,1,0,0,1,1,0 back-to-back -> one cycle after the 8th bit: a=4'hA, b=4'h6, out_valid=1; after handshake, pair_count=1.
REQ-033 With out_ready=0, stream pair A/6 then pair 3/C -> a=A, b=6 held; in_ready=0 after 16th bit (FULL); raise out_ready -> next cycle a=3, b=C, out_valid=1; pair_count=1.
REQ-034 With in_valid toggling every other cycle, stream 1111,0001 -> a=F, b=1; gaps do not shift data.
REQ-035 Stream 3 bits, assert abort together with a 4th bit, then stream 0101,1001 -> a=5, b=9; the aborted bits leave no trace.
REQ-036 Assert rst asynchronously in FULL with out_valid=1 -> all outputs at reset values before the next clock edge.
REQ-037 Perform 256 handshakes -> pair_count wraps to 0.
